// File: rtl/lp805x_clk_pkg.sv
// Shared types and helpers for the lp805x clock-enable fabric.
package lp805x_clk_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_GAP_CYC = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cen_div_cnt.sv
// Programmable divider: registered one-cycle cen, one cycle after cnt reaches div.
// hold clears the counter and suppresses terminal count (dead gap).
module cen_div_cnt #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] div,
  input  logic            hold,
  output logic            tc,
  output logic            cen
);

  logic [DIVW-1:0] cnt_d, cnt_q;
  logic            cen_d, cen_q;

  // Live compare: shrinking div below cnt forces an immediate terminal count.
  assign tc = !hold && (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q + DIVW'(1);
    if (hold || tc) cnt_d = '0;
    cen_d = tc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      cen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cen_q <= cen_d;
    end
  end

  assign cen = cen_q;

endmodule

// File: rtl/cen_sel_mux.sv
// Clock-enable source selector: switches divider only at period end, then a dead gap.
// cen latency 1 cycle from terminal count; requests are strobes, rejects pulse sel_err.
module cen_sel_mux
  import lp805x_clk_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int SELW    = clog2(NSRC),
  parameter int DIVW    = 8,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*DIVW-1:0] div_cfg,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_stb,
  output logic                 cen,
  output logic [SELW-1:0]      cur_sel,
  output logic                 switching,
  output logic                 sel_err
);

  localparam int GAPW = 4;

  state_t          state_d, state_q;
  logic [SELW-1:0] cur_sel_d, cur_sel_q;
  logic [SELW-1:0] pend_sel_d, pend_sel_q;
  logic            switching_d, switching_q;
  logic            sel_err_d, sel_err_q;
  logic [GAPW-1:0] gap_d, gap_q;

  logic [DIVW-1:0] div_act;
  logic [SELW-1:0] pend_nxt;
  logic            sel_ok;
  logic            tc;

  always_comb begin
    div_act = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (cur_sel_q == SELW'(i)) div_act = div_cfg[i*DIVW +: DIVW];
    end
  end

  assign sel_ok = int'(sel) < NSRC;

  cen_div_cnt #(.DIVW(DIVW)) u_div (
    .clk  (clk),
    .rst  (rst),
    .div  (div_act),
    .hold (state_q == ST_GAP),
    .tc   (tc),
    .cen  (cen)
  );

  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    pend_sel_d  = pend_sel_q;
    switching_d = switching_q;
    sel_err_d   = 1'b0;
    gap_d       = gap_q;
    pend_nxt    = pend_sel_q;
    case (state_q)
      ST_RUN: begin
        if (sel_stb) begin
          if (!sel_ok) begin
            sel_err_d = 1'b1;
          end else if (sel != cur_sel_q) begin
            pend_sel_d  = sel;
            switching_d = 1'b1;
            state_d     = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (sel_stb && !sel_ok) sel_err_d = 1'b1;
        if (sel_stb && sel_ok) pend_nxt = sel;
        pend_sel_d = pend_nxt;
        // The final old-source cen still goes out; the gap starts after it.
        if (tc) begin
          if (GAP_CYC == 0) begin
            cur_sel_d   = pend_nxt;
            switching_d = 1'b0;
            state_d     = ST_RUN;
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (sel_stb) sel_err_d = 1'b1;
        if (gap_q == GAPW'(GAP_CYC - 1)) begin
          cur_sel_d   = pend_sel_q;
          switching_d = 1'b0;
          state_d     = ST_RUN;
        end else begin
          gap_d = gap_q + GAPW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cur_sel_q   <= '0;
      pend_sel_q  <= '0;
      switching_q <= 1'b0;
      sel_err_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      switching_q <= switching_d;
      sel_err_q   <= sel_err_d;
      gap_q       <= gap_d;
    end
  end

  assign cur_sel   = cur_sel_q;
  assign switching = switching_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_cen_sel_mux.sv
// Randomised scoreboard bench for cen_sel_mux against a period/gap reference model.
module tb_cen_sel_mux;

  localparam int NSRC    = 3;
  localparam int SELW    = 2;
  localparam int DIVW    = 8;
  localparam int GAP_CYC = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NSRC*DIVW-1:0] div_cfg;
  logic [SELW-1:0]      sel = '0;
  logic                 sel_stb = 1'b0;
  logic                 cen;
  logic [SELW-1:0]      cur_sel;
  logic                 switching;
  logic                 sel_err;

  cen_sel_mux #(.NSRC(NSRC), .SELW(SELW), .DIVW(DIVW), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_cfg   (div_cfg),
    .sel       (sel),
    .sel_stb   (sel_stb),
    .cen       (cen),
    .cur_sel   (cur_sel),
    .switching (switching),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            cen;
    logic [SELW-1:0] cur;
    logic            sw;
    logic            err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference: where we are inside the current period, whether a switch is
  // waiting for the period to finish, and how many dead cycles remain.
  int m_cur, m_pend, m_pos, m_gap_left;
  bit m_waiting, m_in_gap, m_sw;

  function automatic int slice(input int idx);
    logic [NSRC*DIVW-1:0] v;
    v = div_cfg;
    return int'(v[idx*DIVW +: DIVW]);
  endfunction

  task automatic model_reset();
    m_cur = 0; m_pend = 0; m_pos = 0; m_gap_left = 0;
    m_waiting = 0; m_in_gap = 0; m_sw = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit pulse, err, was_waiting, valid;
    pulse = 0; err = 0;
    valid = int'(sel) < NSRC;
    if (!rst) begin
      model_reset();
    end else if (m_in_gap) begin
      if (sel_stb) err = 1;
      m_pos = 0;
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_cur = m_pend; m_sw = 0; m_in_gap = 0;
      end
    end else begin
      was_waiting = m_waiting;
      if (sel_stb) begin
        if (!valid) err = 1;
        else if (m_waiting) m_pend = int'(sel);
        else if (int'(sel) != m_cur) begin
          m_pend = int'(sel); m_waiting = 1; m_sw = 1;
        end
      end
      if (m_pos >= slice(m_cur)) begin
        pulse = 1;
        m_pos = 0;
        if (was_waiting) begin
          m_waiting = 0;
          if (GAP_CYC == 0) begin
            m_cur = m_pend; m_sw = 0;
          end else begin
            m_in_gap = 1; m_gap_left = GAP_CYC;
          end
        end
      end else begin
        m_pos++;
      end
    end
    e.cen = pulse;
    e.cur = SELW'(m_cur);
    e.sw  = m_sw;
    e.err = err;
  endtask

  task automatic step(input logic stb, input logic [SELW-1:0] s);
    exp_t e;
    sel_stb = stb;
    sel     = s;
    model_step(e);
    @(posedge clk);
    #1;
    sel_stb = 1'b0;
    cyc++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic set_slice(input int idx, input int v);
    div_cfg[idx*DIVW +: DIVW] = DIVW'(v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (cen === e.cen && cur_sel === e.cur && switching === e.sw && sel_err === e.err)
          n_pass++;
        else
          $display("FAIL out cyc%0d: cen/cur_sel/switching/sel_err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                   cyc, cen, cur_sel, switching, sel_err, e.cen, e.cur, e.sw, e.err);
      end
    end
  end

  initial begin : stim
    int guard;
    model_reset();
    div_cfg = '0;
    set_slice(0, 3); set_slice(1, 5); set_slice(2, 9);

    // Reset held for 3 cycles, then default source at div 3.
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(14);

    // Clean switch to source 2, requested mid-period.
    idle(1);
    step(1'b1, 2'd2);
    idle(40);

    // Invalid index and redundant request.
    step(1'b1, 2'd3);
    idle(3);
    step(1'b1, 2'd2);
    idle(5);

    // Back to 0, then retarget 1 -> 2 during PEND, and a request during GAP.
    step(1'b1, 2'd0);
    idle(30);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    guard = 0;
    while (!m_in_gap && guard < 50) begin step(1'b0, '0); guard++; end
    step(1'b1, 2'd1);
    idle(25);

    // Live shrink of the active divisor while cnt is far past the new value.
    set_slice(2, 200);
    guard = 0;
    while (m_pos != 150 && guard < 400) begin step(1'b0, '0); guard++; end
    set_slice(2, 10);
    idle(30);

    // Asynchronous reset during the dead gap.
    step(1'b1, 2'd1);
    guard = 0;
    while (!m_in_gap && guard < 50) begin step(1'b0, '0); guard++; end
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    n_chk++;
    if (cen === 1'b0 && switching === 1'b0 && cur_sel === '0 && sel_err === 1'b0)
      n_pass++;
    else
      $display("FAIL async_rst: cen/switching/cur_sel got %b/%b/%0d want 0/0/0", cen, switching, cur_sel);
    idle(2);
    rst = 1'b1;
    idle(20);

    // Random traffic with small divisors, including div=0 and invalid indices.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) set_slice($urandom_range(NSRC - 1), $urandom_range(6));
      if ($urandom_range(7) == 0) step(1'b1, SELW'($urandom_range(3)));
      else step(1'b0, '0);
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: pending expectations got %0d want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
